io_ram_datapath: RTL and testbench
==================================

IO_RAM_DATAPATH -- requirements
Module: io_ram_datapath

Interface
REQ-001 Parameter RAM_WORDS, default 256: data RAM depth in 32-bit words (1 KiB).
REQ-002 Parameter CLK_DIV, default 4: clock cycles per UART bit (>=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 address  input  32  byte address of current access.
REQ-006 wd  input  32  write data; the byte/half is taken from its low bits.
REQ-007 we  input  1  write enable; the write commits at the next rising clk.
REQ-008 mem_ctrl  input  2  access size: 00 byte signed, 01 half signed, 10 word, 11 byte unsigned.
REQ-009 rx  input  1  UART receive line; idles high.
REQ-010 rd  output  32  combinational read data for address/mem_ctrl.
REQ-011 tx  output  1  UART transmit line; idles high.
REQ-012 gpio_out  output  32  GPIO output register.

Function
REQ-013 Memory map: 0x0000_0000-0x0000_03FF RAM (word index address[9:2] for the default depth); 0x8000_0000 UART_TX; 0x8000_0004 UART_STAT; 0x8000_0008 UART_RX; 0x8000_000C GPIO.
REQ-014 Unmapped addresses SHALL read 0, and writes to them SHALL be ignored.
REQ-015 RAM reads SHALL be combinational (zero latency).
REQ-016 RAM writes SHALL be synchronous with byte enables.
REQ-017 Byte write lane = address[1:0].
REQ-018 Half write lane = address[1], with address[0] ignored.
REQ-019 Word writes ignore address[1:0].
REQ-020 Read lane selection SHALL match write lane selection; byte/half results are right-aligned.
REQ-021 Byte/half reads with mem_ctrl 00/01 are sign-extended; reads with mem_ctrl 11 are zero-extended.
REQ-022 IO registers are word-wide: accesses use the full word regardless of mem_ctrl; for writes, the IO register takes wd as-is.
REQ-023 GPIO: a write loads gpio_out <= wd; a read returns gpio_out.
REQ-024 UART_TX write: when the transmitter is idle, start a frame with byte wd[7:0]; when busy, ignore the write.
REQ-025 UART_TX read: returns 0.
REQ-026 UART_STAT read: {30'b0, rx_valid, tx_busy}.
REQ-027 UART_STAT write: any write clears rx_valid.
REQ-028 UART_RX read: {24'b0, rx_byte}; reading has no side effect.
REQ-029 TX frame format: 8N1 — start bit 0, data LSB first, stop bit 1; each bit lasts CLK_DIV cycles.
REQ-030 tx_busy SHALL be set in the cycle after an accepted write and SHALL clear after the stop bit completes (10*CLK_DIV cycles).
REQ-031 TX state machine states: IDLE, START, DATA (bit counter 0-7), STOP, then back to IDLE.
REQ-032 rx SHALL pass through a 2-flop synchronizer before use.
REQ-033 RX state machine states: WAIT_IDLE, IDLE, START, DATA, STOP.
REQ-034 RX start detection: a falling edge seen in IDLE; the receiver samples at mid-bit (CLK_DIV/2 into the start bit, then every CLK_DIV).
REQ-035 Start validation: if the start bit is high at mid-sample, return to IDLE.
REQ-036 Stop bit sampled 1: latch rx_byte and set rx_valid, overwriting any unread byte.
REQ-037 Stop bit sampled 0 (framing error): discard the byte and enter WAIT_IDLE.
REQ-038 WAIT_IDLE: leave only after the synchronized rx has been high for one full bit time, so a line held low produces no data.
REQ-039 Simultaneous events: if a UART_STAT write and a completed RX frame occur in the same cycle, rx_valid ends set.
REQ-040 RAM contents SHALL NOT be reset or initialised; X before the first write is acceptable.

Reset
REQ-041 On rst=1 at a clock edge: tx=1, tx_busy=0, rx_valid=0, rx_byte=0, gpio_out=0, and both state machines go to their idle state (RX goes to WAIT_IDLE).
REQ-042 Reset asserted mid-frame SHALL abort the frame; tx SHALL be 1 from the next cycle.
REQ-043 Reset SHALL NOT alter RAM.

Verification
REQ-044 Scenario: word write 0xDEADBEEF @0x4, then word read @0x4 -> 0xDEADBEEF; byte read mem_ctrl=00 @0x5 -> 0xFFFFFFBE; mem_ctrl=11 @0x5 -> 0x000000BE.
REQ-045 Scenario: half write 0x1234 @0x6 over 0xDEADBEEF -> word read 0x1234BEEF; half read @0x4 -> 0xFFFFBEEF.
REQ-046 Scenario: write 0xA5A5A5A5 to 0x8000_000C -> gpio_out=0xA5A5A5A5, read returns same; rst -> gpio_out=0.
REQ-047 Scenario: write 0x55 to UART_TX -> tx emits 0,1,0,1,0,1,0,1,0,1 each CLK_DIV cycles; UART_STAT bit0=1 during the frame, 0 after.
REQ-048 Scenario: drive an rx frame for 0x3C after idle high -> UART_STAT=0x2, UART_RX=0x3C; write UART_STAT -> bit1 clears.
REQ-049 Scenario: rx held 0 from reset for 40 cycles (address=4, we=0) -> rx_valid stays 0, rd equals RAM word 1, no X on tx or gpio_out.

Source files
------------

// File: rtl/io_ram_datapath.sv
// Data RAM with byte/half/word access plus memory-mapped UART (8N1) and GPIO.
// Reads are combinational; RAM writes and all IO state update on the rising clock edge.
module io_ram_datapath #(
    parameter int RAM_WORDS = 256,
    parameter int CLK_DIV   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] wd,
    input  logic        we,
    input  logic [1:0]  mem_ctrl,
    input  logic        rx,
    output logic [31:0] rd,
    output logic        tx,
    output logic [31:0] gpio_out
);

    localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int CW     = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
    localparam logic [31:0] ADDR_TX   = 32'h8000_0000;
    localparam logic [31:0] ADDR_STAT = 32'h8000_0004;
    localparam logic [31:0] ADDR_RX   = 32'h8000_0008;
    localparam logic [31:0] ADDR_GPIO = 32'h8000_000C;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_WAIT_IDLE, RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic [31:0]       mem [RAM_WORDS];
    logic              ram_sel_s;
    logic [RAM_AW-1:0] ram_idx_s;
    logic [31:0]       ram_word_s, ram_rd_s, io_rd_s;
    logic [7:0]        byte_s;
    logic [15:0]       half_s;
    logic              tx_wr_s, stat_wr_s, gpio_wr_s, tx_busy_s;

    tx_state_t   tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_q, tx_d;
    logic [31:0] gpio_q, gpio_d;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_t   rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_valid_q, rx_valid_d;

    assign ram_sel_s = (address[31:RAM_AW+2] == {(30-RAM_AW){1'b0}});
    assign ram_idx_s = address[RAM_AW+1:2];
    assign tx_wr_s   = we && (address == ADDR_TX);
    assign stat_wr_s = we && (address == ADDR_STAT);
    assign gpio_wr_s = we && (address == ADDR_GPIO);
    assign tx_busy_s = (tx_state_q != TX_IDLE);
    assign tx        = tx_q;
    assign gpio_out  = gpio_q;

    // Read path: lane select and extension for RAM, word-wide IO registers.
    always_comb begin
        ram_word_s = mem[ram_idx_s];
        case (address[1:0])
            2'd0:    byte_s = ram_word_s[7:0];
            2'd1:    byte_s = ram_word_s[15:8];
            2'd2:    byte_s = ram_word_s[23:16];
            default: byte_s = ram_word_s[31:24];
        endcase
        half_s = address[1] ? ram_word_s[31:16] : ram_word_s[15:0];
        case (mem_ctrl)
            2'b00:   ram_rd_s = {{24{byte_s[7]}}, byte_s};
            2'b01:   ram_rd_s = {{16{half_s[15]}}, half_s};
            2'b10:   ram_rd_s = ram_word_s;
            default: ram_rd_s = {24'h00_0000, byte_s};
        endcase
        case (address)
            ADDR_TX:   io_rd_s = 32'h0000_0000;
            ADDR_STAT: io_rd_s = {30'h0, rx_valid_q, tx_busy_s};
            ADDR_RX:   io_rd_s = {24'h00_0000, rx_byte_q};
            ADDR_GPIO: io_rd_s = gpio_q;
            default:   io_rd_s = 32'h0000_0000;
        endcase
        rd = ram_sel_s ? ram_rd_s : io_rd_s;
    end

    // RAM write port with byte enables; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (we && ram_sel_s) begin
            case (mem_ctrl)
                2'b01:   mem[ram_idx_s][{address[1], 4'b0000} +: 16] <= wd[15:0];
                2'b10:   mem[ram_idx_s] <= wd;
                default: mem[ram_idx_s][{address[1:0], 3'b000} +: 8] <= wd[7:0];
            endcase
        end
    end

    // Transmitter next state; tx_d is the line level for the bit being entered.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (tx_wr_s) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = '0;
                    tx_shift_d = wd[7:0];
                    tx_d       = 1'b0;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = 3'd0;
                    tx_d       = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_state_d = TX_IDLE;
                    tx_cnt_d   = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_d       = 1'b1;
            end
        endcase
    end

    // Receiver, status flag and GPIO next state; a completed frame beats a status clear.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_byte_d  = rx_byte_q;
        gpio_d     = gpio_wr_s ? wd : gpio_q;
        if (stat_wr_s) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
        case (rx_state_q)
            RX_WAIT_IDLE: begin
                if (!rx_s2_q) begin
                    rx_cnt_d = '0;
                end else if (rx_cnt_q == BIT_LAST) begin
                    rx_state_d = RX_IDLE;
                    rx_cnt_d   = '0;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    rx_state_d = (rx_bit_q == 3'd7) ? RX_STOP : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_s2_q) begin
                        rx_state_d = RX_IDLE;
                        rx_byte_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_state_d = RX_WAIT_IDLE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: begin
                rx_state_d = RX_WAIT_IDLE;
                rx_cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            tx_q       <= 1'b1;
            gpio_q     <= 32'h0000_0000;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_WAIT_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_byte_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            gpio_q     <= gpio_d;
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
        end
    end

endmodule

// File: tb/tb_io_ram_datapath.sv
// Randomized scoreboard bench for io_ram_datapath: a byte-level memory/IO model
// predicts reads and TX frames; independent monitors compare what the DUT presents.
module tb_io_ram_datapath;

    localparam int CLK_DIV   = 4;
    localparam int RAM_WORDS = 256;
    localparam int FRAME     = 10 * CLK_DIV;
    localparam logic [31:0] A_TX   = 32'h8000_0000;
    localparam logic [31:0] A_STAT = 32'h8000_0004;
    localparam logic [31:0] A_RX   = 32'h8000_0008;
    localparam logic [31:0] A_GPIO = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        rst, we, rx, tx;
    logic [31:0] address, wd, rd, gpio_out;
    logic [1:0]  mem_ctrl;

    io_ram_datapath #(.RAM_WORDS(RAM_WORDS), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .address(address), .wd(wd), .we(we),
        .mem_ctrl(mem_ctrl), .rx(rx), .rd(rd), .tx(tx), .gpio_out(gpio_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rst_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rst) rst_cnt <= rst_cnt + 1;

    // reference model state
    logic [7:0]  mem_m [1024];
    logic [31:0] gpio_m;
    logic        rxv_m;
    logic [7:0]  rxb_m;
    int          tx_start_m = -1000;
    logic [7:0]  tx_exp_q [$];

    // read scoreboard
    logic [31:0] exp_q [$];
    string       name_q [$];
    logic        chk_req = 1'b0;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic bit busy_at(int k);
        return (k >= tx_start_m) && (k < tx_start_m + FRAME);
    endfunction

    function automatic logic [31:0] model_read(logic [31:0] a, logic [1:0] c);
        logic [9:0] h, w;
        h = {a[9:1], 1'b0};
        w = {a[9:2], 2'b00};
        if (a < 32'h0000_0400) begin
            case (c)
                2'b00:   return {{24{mem_m[a[9:0]][7]}}, mem_m[a[9:0]]};
                2'b01:   return {{16{mem_m[h+10'd1][7]}}, mem_m[h+10'd1], mem_m[h]};
                2'b10:   return {mem_m[w+10'd3], mem_m[w+10'd2], mem_m[w+10'd1], mem_m[w]};
                default: return {24'h0, mem_m[a[9:0]]};
            endcase
        end
        if (a == A_STAT) return {30'h0, rxv_m, busy_at(cyc)};
        if (a == A_RX)   return {24'h0, rxb_m};
        if (a == A_GPIO) return gpio_m;
        return 32'h0;
    endfunction

    function automatic void model_write(logic [31:0] a, logic [31:0] d, logic [1:0] c, int n);
        logic [9:0] h, w;
        h = {a[9:1], 1'b0};
        w = {a[9:2], 2'b00};
        if (a < 32'h0000_0400) begin
            case (c)
                2'b01: begin mem_m[h] = d[7:0]; mem_m[h+10'd1] = d[15:8]; end
                2'b10: for (int i = 0; i < 4; i++) mem_m[w + 10'(i)] = d[8*i +: 8];
                default: mem_m[a[9:0]] = d[7:0];
            endcase
        end else if (a == A_TX) begin
            if (!busy_at(n - 1)) begin
                tx_start_m = n;
                tx_exp_q.push_back(d[7:0]);
            end
        end else if (a == A_STAT) begin
            rxv_m = 1'b0;
        end else if (a == A_GPIO) begin
            gpio_m = d;
        end
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] c);
        address = a; wd = d; mem_ctrl = c; we = 1'b1;
        model_write(a, d, c, cyc + 1);
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [1:0] c, input string nm);
        address = a; mem_ctrl = c; we = 1'b0;
        exp_q.push_back(model_read(a, c));
        name_q.push_back(nm);
        chk_req = 1'b1;
        @(posedge clk); #1;
        chk_req = 1'b0;
    endtask

    task automatic idle(input int n);
        we = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        gpio_m = 32'h0; rxv_m = 1'b0; rxb_m = 8'h00; tx_start_m = -1000;
        tx_exp_q.delete();
        check("tx_after_reset", {31'h0, tx}, 32'h1);
        check("gpio_after_reset", gpio_out, 32'h0);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_ok);
        we = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rx = (i == 0) ? 1'b0 : ((i == 9) ? stop_ok : b[i-1]);
            repeat (CLK_DIV) @(posedge clk);
            #1;
        end
        rx = 1'b1;
        idle(3 * CLK_DIV);
        if (stop_ok) begin
            rxv_m = 1'b1;
            rxb_m = b;
        end
    endtask

    // read monitor: compares rd whenever a read is being presented
    initial begin : read_mon
        logic [31:0] e;
        string nm;
        forever begin
            @(negedge clk);
            if (chk_req) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL read_scoreboard: rd=%h presented with no expectation", rd);
                end else begin
                    e = exp_q.pop_front();
                    nm = name_q.pop_front();
                    check(nm, rd, e);
                end
            end
        end
    end

    // TX monitor: decodes frames at mid-bit and compares against accepted writes
    initial begin : tx_mon
        int rc;
        logic [7:0] got;
        logic sb, stb;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                rc = rst_cnt;
                repeat (CLK_DIV / 2) @(negedge clk);
                sb = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(negedge clk);
                    got[i] = tx;
                end
                repeat (CLK_DIV) @(negedge clk);
                stb = tx;
                if (rst_cnt == rc) begin
                    check("tx_start_bit", {31'h0, sb}, 32'h0);
                    check("tx_stop_bit", {31'h0, stb}, 32'h1);
                    if (tx_exp_q.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL tx_frame: unexpected frame %h on tx", got);
                    end else begin
                        check("tx_byte", {24'h0, got}, {24'h0, tx_exp_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: time limit reached, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] a, d;
        logic [1:0]  c;
        logic [31:0] unm [4];
        unm[0] = 32'h0000_0400; unm[1] = 32'h8000_0010;
        unm[2] = 32'hFFFF_FFFC; unm[3] = 32'h4000_0000;
        rst = 1'b1; we = 1'b0; address = 32'h0; wd = 32'h0; mem_ctrl = 2'b10; rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        rd_chk(A_STAT, 2'b10, "stat_reset");
        rd_chk(A_RX, 2'b10, "rx_reset");
        rd_chk(A_GPIO, 2'b10, "gpio_reset");

        for (int w = 0; w < RAM_WORDS; w++) wr(32'(w * 4), $urandom, 2'b10);
        wr(32'h4, 32'hDEAD_BEEF, 2'b10);
        rd_chk(32'h4, 2'b10, "word_at_4");
        rd_chk(32'h5, 2'b00, "byte_signed_at_5");
        rd_chk(32'h5, 2'b11, "byte_unsigned_at_5");
        wr(32'h6, 32'h0000_1234, 2'b01);
        rd_chk(32'h4, 2'b10, "word_after_half");
        rd_chk(32'h4, 2'b01, "half_signed_at_4");
        rd_chk(32'h7, 2'b01, "half_odd_addr");

        for (int i = 0; i < 160; i++) begin
            c = 2'($urandom_range(0, 3));
            d = $urandom;
            a = ($urandom_range(0, 9) == 0) ? unm[$urandom_range(0, 3)] + 32'($urandom_range(0, 3) * 4)
                                            : 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 2) == 0) wr(a, d, c);
            else rd_chk(a, c, "random_access");
        end

        wr(A_GPIO, 32'hA5A5_A5A5, 2'b10);
        check("gpio_out_write", gpio_out, 32'hA5A5_A5A5);
        rd_chk(A_GPIO, 2'b00, "gpio_read");
        wr(A_GPIO, $urandom, 2'b00);
        rd_chk(A_GPIO, 2'b11, "gpio_read_byte_ctrl");
        do_reset();
        rd_chk(A_GPIO, 2'b10, "gpio_after_reset_rd");
        rd_chk(32'h4, 2'b10, "ram_kept_over_reset");

        wr(A_TX, 32'h0000_0055, 2'b10);
        for (int i = 0; i < FRAME + 6; i++) begin
            if (i == 5) rd_chk(A_TX, 2'b10, "tx_reg_reads_zero");
            else rd_chk(A_STAT, 2'b10, "stat_during_tx");
        end
        wr(A_TX, 32'h0000_00A3, 2'b10);
        idle(5);
        wr(A_TX, 32'h0000_0011, 2'b10);
        idle(FRAME + 5);
        for (int i = 0; i < 6; i++) begin
            wr(A_TX, $urandom, 2'b10);
            idle($urandom_range(0, 50));
            rd_chk(A_STAT, 2'b10, "stat_random_tx");
        end
        idle(FRAME + 5);

        wr(A_TX, 32'h0000_0000, 2'b10);
        idle(3 * CLK_DIV);
        do_reset();
        rd_chk(A_STAT, 2'b10, "stat_after_tx_abort");
        idle(FRAME + 10);

        send_rx(8'h3C, 1'b1);
        rd_chk(A_STAT, 2'b10, "stat_rx_valid");
        rd_chk(A_RX, 2'b10, "rx_byte_3c");
        rd_chk(A_RX, 2'b10, "rx_read_no_side_effect");
        wr(A_STAT, 32'h0, 2'b10);
        rd_chk(A_STAT, 2'b10, "stat_cleared");
        send_rx(8'h81, 1'b1);
        send_rx(8'h7E, 1'b1);
        rd_chk(A_RX, 2'b10, "rx_overwrite");
        wr(A_STAT, $urandom, 2'b10);
        send_rx(8'hF0, 1'b0);
        rd_chk(A_STAT, 2'b10, "stat_framing_error");
        rd_chk(A_RX, 2'b10, "rx_framing_kept");
        rx = 1'b0; idle(1); rx = 1'b1; idle(3 * CLK_DIV);
        rd_chk(A_STAT, 2'b10, "stat_after_glitch");
        for (int i = 0; i < 5; i++) begin
            send_rx(8'($urandom), ($urandom_range(0, 3) != 0));
            rd_chk(A_STAT, 2'b10, "stat_random_rx");
            rd_chk(A_RX, 2'b10, "rx_random");
            if ($urandom_range(0, 1) == 1) wr(A_STAT, 32'h0, 2'b10);
        end

        rx = 1'b0;
        do_reset();
        for (int i = 0; i < 40; i++) rd_chk(32'h4, 2'b10, "ram_word1_rx_low");
        check("tx_known_rx_low", {31'h0, $isunknown(tx)}, 32'h0);
        check("gpio_known_rx_low", {31'h0, $isunknown(gpio_out)}, 32'h0);
        rd_chk(A_STAT, 2'b10, "stat_rx_held_low");
        rx = 1'b1;
        idle(3 * CLK_DIV);
        rd_chk(A_STAT, 2'b10, "stat_after_release");
        send_rx(8'hC3, 1'b1);
        rd_chk(A_RX, 2'b10, "rx_after_release");

        idle(FRAME + 10);
        check("tx_frames_pending", 32'(tx_exp_q.size()), 32'h0);
        check("reads_pending", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
